// File: rtl/dual_port_ram_reader.sv
// rtl/dual_port_ram_reader.sv - block reader for RAM port B with a 2-entry stream buffer.
// Issues one read per cycle while the buffer has room, then streams words out on m_valid/m_ready.
module dual_port_ram_reader #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   length,
   output logic              busy,
   output logic              done,
   output logic              rd_en_b,
   output logic [ADDR_W-1:0] addr_b,
   input  logic [DATA_W-1:0] data_out_b,
   output logic              m_valid,
   output logic [DATA_W-1:0] m_data,
   input  logic              m_ready
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [ADDR_W-1:0] PTR_ONE = 1;
   localparam logic [ADDR_W:0]   CNT_ONE = 1;

   state_t              state;
   logic [ADDR_W-1:0]   issue_ptr;
   logic [ADDR_W:0]     issue_cnt;
   logic [ADDR_W:0]     beat_cnt;
   logic                inflight;
   logic [1:0]          buf_count;
   logic [DATA_W-1:0]   buf_head;
   logic [DATA_W-1:0]   buf_tail;
   logic                done_q;
   logic                pop;
   logic [2:0]          occ_next;

   assign m_valid  = (buf_count != 2'd0);
   assign m_data   = buf_head;
   assign pop      = m_valid & m_ready;
   // Occupancy after this edge if no new read were issued; a read is allowed only if it leaves room.
   assign occ_next = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, pop};
   assign rd_en_b  = (state == RUN) && (issue_cnt != '0) && (occ_next < 3'd2);
   assign addr_b   = issue_ptr;
   assign busy     = (state == RUN);
   assign done     = done_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         issue_ptr <= '0;
         issue_cnt <= '0;
         beat_cnt  <= '0;
         inflight  <= 1'b0;
         buf_count <= 2'd0;
         buf_head  <= '0;
         buf_tail  <= '0;
         done_q    <= 1'b0;
      end else begin
         done_q   <= 1'b0;
         inflight <= rd_en_b;

         case (state)
            IDLE: begin
               if (start) begin
                  if (length != '0) begin
                     state     <= RUN;
                     issue_ptr <= base_addr;
                     issue_cnt <= length;
                     beat_cnt  <= length;
                  end else begin
                     done_q <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (rd_en_b) begin
                  issue_ptr <= issue_ptr + PTR_ONE;
                  issue_cnt <= issue_cnt - CNT_ONE;
               end
               if (pop) begin
                  beat_cnt <= beat_cnt - CNT_ONE;
                  if (beat_cnt == CNT_ONE) begin
                     state  <= IDLE;
                     done_q <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase

         // Two-entry FIFO held as head/tail registers; the head always drives m_data.
         case ({inflight, pop})
            2'b10: begin
               if (buf_count == 2'd0) buf_head <= data_out_b;
               else                   buf_tail <= data_out_b;
               buf_count <= buf_count + 2'd1;
            end
            2'b01: begin
               buf_head  <= buf_tail;
               buf_count <= buf_count - 2'd1;
            end
            2'b11: begin
               if (buf_count == 2'd1) begin
                  buf_head <= data_out_b;
               end else begin
                  buf_head <= buf_tail;
                  buf_tail <= data_out_b;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/dual_port_ram_reader.md
Name: dual_port_ram_reader

Overview:
- Read-side master for the dual-port RAM.
- Drives the RAM's port B (rd_en_b/addr_b) to fetch a block of consecutive words from base_addr.
- Streams the fetched words out on a valid/ready interface.
- Absorbs the RAM's 1-cycle registered read latency with a 2-entry output buffer, so backpressure never loses or duplicates data. Full rate is 1 word/cycle.

Parameters:
- ADDR_W, 4, RAM address width (depth 2^ADDR_W).
- DATA_W, 8, RAM/stream data width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a block read; sampled only in IDLE.
- base_addr  input  ADDR_W  first RAM address; sampled with start.
- length  input  ADDR_W+1  word count, 0..2^ADDR_W; sampled with start.
- busy  output  1  high while a block read is in progress.
- done  output  1  1-cycle pulse when the block is complete.
- rd_en_b  output  1  RAM port-B read enable.
- addr_b  output  ADDR_W  RAM port-B address.
- data_out_b  input  DATA_W  RAM port-B read data; valid the cycle after rd_en_b.
- m_valid  output  1  stream data valid.
- m_data  output  DATA_W  stream data.
- m_ready  input  1  downstream ready.

Behaviour:
- Reset (async, active-high): state IDLE; busy, done, rd_en_b, m_valid = 0; addr_b, m_data = 0. Buffer count, in-flight flag and counters are cleared. In-flight RAM data is discarded.
- States: IDLE, RUN.
  - IDLE -> RUN: start=1 at a rising edge with length!=0. base_addr is latched into the issue pointer. length is latched into the issue counter and the beat counter.
  - IDLE with start=1, length=0: stays IDLE; done=1 for the next cycle. No RAM read is issued.
  - RUN -> IDLE: at the edge where the final beat handshakes (m_valid&m_ready with beat counter = 1). done=1 for exactly the following cycle.
- busy = (state==RUN). start is ignored while busy.
- Issue rule: in RUN, rd_en_b=1 when issue counter != 0 and (buf_count + inflight - pop) < 2, where pop = m_valid&m_ready.
  - addr_b = issue pointer.
  - On each issue: pointer increments modulo 2^ADDR_W (wraps 15 -> 0 at the default width), and the issue counter decrements.
  - rd_en_b and addr_b are combinational from registered state. rd_en_b = 0 outside RUN.
- Capture: inflight register = rd_en_b delayed one cycle. When inflight=1, data_out_b is written into the 2-entry buffer at that edge.
- Simultaneous capture and pop in the same cycle is legal; the count is unchanged.
- Buffer: in-order (FIFO). m_valid = (buf_count != 0). m_data = head entry.
- While m_valid=1 and m_ready=0, m_data stays stable. The buffer never overflows, because occupancy is at most 2 by the issue rule.
- Latency: with start sampled at edge N, rd_en_b is high during cycle N+1. First m_valid=1 occurs after edge N+2.
- Throughput: with m_ready held high, one beat per cycle, no bubbles.
- Beat counter decrements on each handshake. Exactly `length` beats are produced, in address order.
- Mid-operation reset: immediate return to reset values. A later start runs cleanly.

Test Plan:
- Reset check: assert rst mid-cycle -> busy, done, rd_en_b, m_valid, addr_b and m_data are all 0 immediately, without waiting for a clock edge.
- Full-rate read: RAM preloaded mem[i]=i*3; start base=0 length=16 with m_ready=1 -> 16 beats on consecutive cycles with data 0,3,...,45. First m_valid 2 cycles after start. A single done pulse after the last beat; busy low afterwards.
- Backpressure: same block, m_ready toggling 1,0,1,0 then held low 5 cycles -> no loss or duplication, m_data stable while stalled. Occupancy (buf_count + inflight) never exceeds 2. Data order still 0,3,...,45.
- Wrap-around: base=14, length=4 -> addr_b sequence 14,15,0,1; beats 42,45,0,3; done once.
- Edge starts: length=0 -> done pulse the next cycle, rd_en_b never asserted. A start pulse while busy (base=5, length=2) is ignored; the current block completes unchanged.
- Reset mid-run: assert rst after 5 beats of a 16-word read -> all outputs at reset values. Then start base=8 length=3 -> beats 24,27,30 and done.
